// File: rtl/ex_mem_stage_pkg.sv
// ----------------------------------------------------------------------------
// em_pkg: shared types for the EX/MEM elastic pipeline stage.
//   EM_DATA_WIDTH : width of ALU result, store data and PC+4
//   EM_WIDTH      : destination register index width
//   em_payload_t  : full EX->MEM control/data bundle
//   em_state_e    : buffer occupancy states
// ----------------------------------------------------------------------------
package em_pkg;

  localparam int EM_DATA_WIDTH = 32;
  localparam int EM_WIDTH      = 5;

  typedef struct packed {
    logic                     RegWrite;
    logic [1:0]               ResultSrc;
    logic                     MemWrite;
    logic                     MemRead;
    logic [2:0]               modeAddr;
    logic [EM_DATA_WIDTH-1:0] ALUResult;
    logic [EM_DATA_WIDTH-1:0] WriteData;
    logic [EM_WIDTH-1:0]      Rd;
    logic [EM_DATA_WIDTH-1:0] PCPlus4;
  } em_payload_t;

  typedef enum logic [1:0] {
    EM_EMPTY = 2'd0,
    EM_FULL  = 2'd1,
    EM_SKID  = 2'd2
  } em_state_e;

endpackage

// File: rtl/ex_mem_stage_if.sv
// ----------------------------------------------------------------------------
// ex_mem_stage_if: EX-side and MEM-side handshake plus payload of the EX/MEM
// stage.
//   slave  : view used by the stage (takes E side and ready_m, drives
//            ready_e and the M side)
//   master : view used by whatever surrounds the stage
// ----------------------------------------------------------------------------
interface ex_mem_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 5
);
  logic                  valid_e;
  logic                  ready_e;
  logic                  RegWriteE;
  logic                  MemWriteE;
  logic                  MemReadE;
  logic [1:0]            ResultSrcE;
  logic [2:0]            modeAddrE;
  logic [DATA_WIDTH-1:0] ALUResultE;
  logic [DATA_WIDTH-1:0] WriteDataE;
  logic [DATA_WIDTH-1:0] PCPlus4E;
  logic [WIDTH-1:0]      RdE;

  logic                  valid_m;
  logic                  ready_m;
  logic                  RegWriteM;
  logic                  MemWriteM;
  logic                  MemReadM;
  logic [1:0]            ResultSrcM;
  logic [2:0]            modeAddrM;
  logic [DATA_WIDTH-1:0] ALUResultM;
  logic [DATA_WIDTH-1:0] WriteDataM;
  logic [DATA_WIDTH-1:0] PCPlus4M;
  logic [WIDTH-1:0]      RdM;

  modport slave (
    input  valid_e, RegWriteE, MemWriteE, MemReadE, ResultSrcE, modeAddrE,
           ALUResultE, WriteDataE, PCPlus4E, RdE, ready_m,
    output ready_e, valid_m, RegWriteM, MemWriteM, MemReadM, ResultSrcM,
           modeAddrM, ALUResultM, WriteDataM, PCPlus4M, RdM
  );

  modport master (
    output valid_e, RegWriteE, MemWriteE, MemReadE, ResultSrcE, modeAddrE,
           ALUResultE, WriteDataE, PCPlus4E, RdE, ready_m,
    input  ready_e, valid_m, RegWriteM, MemWriteM, MemReadM, ResultSrcM,
           modeAddrM, ALUResultM, WriteDataM, PCPlus4M, RdM
  );
endinterface

// File: rtl/ex_mem_stage_skid_buf.sv
// ----------------------------------------------------------------------------
// pipe_skid_buf: generic elastic buffer, strict FIFO order, synchronous flush.
// Build option: EM_SKID_EN
//   defined   : main + skid entry, registered ready_o
//   undefined : main entry only, ready_o = !valid_o | ready_i
// Ports: clk, rst_n (async, active-low), flush_i, valid_i/ready_o/data_i
//        (upstream), valid_o/ready_i/data_o (downstream; data_o is the main
//        entry and holds its last value when invalid).
//
// state     | meaning
// EM_EMPTY  | nothing held, upstream accepted
// EM_FULL   | main entry valid
// EM_SKID   | main and skid valid, upstream stalled (skid build only)
// ----------------------------------------------------------------------------
module pipe_skid_buf
  import em_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  localparam logic [1:0] ST_EMPTY = EM_EMPTY;
  localparam logic [1:0] ST_FULL  = EM_FULL;

  logic [1:0]   state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic         in_fire, out_fire;

  assign valid_o  = (state_q != ST_EMPTY);
  assign data_o   = main_q;
  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;

`ifdef EM_SKID_EN
  localparam logic [1:0] ST_SKID = EM_SKID;

  logic [W-1:0] skid_q, skid_d;
  logic         ready_q;

  assign ready_o = ready_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    // Flush drops everything, including a simultaneous capture.
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_fire) begin
          state_d = ST_FULL;
          main_d  = data_i;
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_d = data_i;
          end else if (in_fire) begin
            state_d = ST_SKID;
            skid_d  = data_i;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: if (out_fire) begin
          state_d = ST_FULL;
          main_d  = skid_q;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      // Registered from next state so ready_m never reaches ready_e.
      ready_q <= (state_d != ST_SKID);
    end
  end
`else
  assign ready_o = ~valid_o | ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else if (in_fire) begin
      state_d = ST_FULL;
      main_d  = data_i;
    end else if (out_fire) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end
`endif

endmodule

// File: rtl/ex_mem_stage.sv
// ----------------------------------------------------------------------------
// ex_mem_stage: elastic EX/MEM pipeline stage.
// Build option: EM_SKID_EN (adds a skid entry and a registered ready_e).
// Ports: clk, rst_n (async, active-low), flush_i (squash held entries),
//        bus (ex_mem_stage_if.slave: valid_e/ready_e + E bundle in,
//        valid_m/ready_m + M bundle out).
// RegWriteM/MemWriteM/MemReadM are qualified by valid_m so bubbles have no
// side effects; the data fields simply hold their last value.
// ----------------------------------------------------------------------------
module ex_mem_stage
  import em_pkg::*;
#(
  parameter int DATA_WIDTH = em_pkg::EM_DATA_WIDTH,
  parameter int WIDTH      = em_pkg::EM_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  ex_mem_stage_if.slave      bus
);

  localparam int PW = $bits(em_payload_t);

  em_payload_t   e_pl, m_pl;
  logic [PW-1:0] m_bits;
  logic          valid_m;

  always_comb begin
    e_pl           = '0;
    e_pl.RegWrite  = bus.RegWriteE;
    e_pl.ResultSrc = bus.ResultSrcE;
    e_pl.MemWrite  = bus.MemWriteE;
    e_pl.MemRead   = bus.MemReadE;
    e_pl.modeAddr  = bus.modeAddrE;
    e_pl.ALUResult = bus.ALUResultE;
    e_pl.WriteData = bus.WriteDataE;
    e_pl.Rd        = bus.RdE;
    e_pl.PCPlus4   = bus.PCPlus4E;
  end

  pipe_skid_buf #(.W(PW)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_i),
    .valid_i (bus.valid_e),
    .ready_o (bus.ready_e),
    .data_i  (e_pl),
    .valid_o (valid_m),
    .ready_i (bus.ready_m),
    .data_o  (m_bits)
  );

  assign m_pl = em_payload_t'(m_bits);

  assign bus.valid_m    = valid_m;
  assign bus.RegWriteM  = m_pl.RegWrite & valid_m;
  assign bus.MemWriteM  = m_pl.MemWrite & valid_m;
  assign bus.MemReadM   = m_pl.MemRead  & valid_m;
  assign bus.ResultSrcM = m_pl.ResultSrc;
  assign bus.modeAddrM  = m_pl.modeAddr;
  assign bus.ALUResultM = m_pl.ALUResult[DATA_WIDTH-1:0];
  assign bus.WriteDataM = m_pl.WriteData[DATA_WIDTH-1:0];
  assign bus.PCPlus4M   = m_pl.PCPlus4[DATA_WIDTH-1:0];
  assign bus.RdM        = m_pl.Rd[WIDTH-1:0];

endmodule

// File: tb/tb_ex_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_mem_stage: directed bench for ex_mem_stage, with a queue model of the
// stage checked on every falling edge, plus literal expectations per scenario.
// Follows EM_SKID_EN the same way as the RTL.
// ----------------------------------------------------------------------------
module tb_ex_mem_stage;
  import em_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic flush_i;

  int vectors     = 0;
  int miscompares = 0;

  ex_mem_stage_if #(.DATA_WIDTH(32), .WIDTH(5)) bus ();

  ex_mem_stage #(.DATA_WIDTH(32), .WIDTH(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_i),
    .bus     (bus)
  );

  always #5 clk = ~clk;

`ifdef EM_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: a FIFO of capacity CAP ----------------
  em_payload_t q[$];
  em_payload_t shown = '0;
  bit          m_rdy, m_in, m_out;
  bit          seen_rd7 = 1'b0;

  function automatic em_payload_t cur_e();
    em_payload_t p;
    p.RegWrite  = bus.RegWriteE;
    p.ResultSrc = bus.ResultSrcE;
    p.MemWrite  = bus.MemWriteE;
    p.MemRead   = bus.MemReadE;
    p.modeAddr  = bus.modeAddrE;
    p.ALUResult = bus.ALUResultE;
    p.WriteData = bus.WriteDataE;
    p.Rd        = bus.RdE;
    p.PCPlus4   = bus.PCPlus4E;
    return p;
  endfunction

  function automatic bit model_ready();
`ifdef EM_SKID_EN
    return q.size() < CAP;
`else
    return (q.size() == 0) || (bus.ready_m === 1'b1);
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      shown = '0;
    end else begin
      m_rdy = model_ready();
      m_in  = (bus.valid_e === 1'b1) && m_rdy;
      m_out = (q.size() > 0) && (bus.ready_m === 1'b1);
      if (flush_i) begin
        q.delete();
      end else begin
        if (m_out) void'(q.pop_front());
        if (m_in) q.push_back(cur_e());
      end
      if (q.size() > 0) shown = q[0];
    end
  end

  em_payload_t exp_p;
  bit          exp_v;
  always @(negedge clk) begin
    exp_v = (q.size() > 0);
    exp_p = exp_v ? q[0] : shown;
    chk("ready_e", 128'(bus.ready_e), 128'(model_ready()));
    chk("valid_m", 128'(bus.valid_m), 128'(exp_v));
    chk("ctrl_m", 128'({bus.RegWriteM, bus.MemWriteM, bus.MemReadM}),
        128'({exp_p.RegWrite & exp_v, exp_p.MemWrite & exp_v, exp_p.MemRead & exp_v}));
    chk("data_m", 128'({bus.ALUResultM, bus.WriteDataM, bus.PCPlus4M, bus.RdM,
                        bus.ResultSrcM, bus.modeAddrM}),
        128'({exp_p.ALUResult, exp_p.WriteData, exp_p.PCPlus4, exp_p.Rd,
              exp_p.ResultSrc, exp_p.modeAddr}));
    if (bus.valid_m === 1'b1 && bus.RdM === 5'd7) seen_rd7 = 1'b1;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_e(input logic v, input logic [31:0] alu, input logic [4:0] rd,
                       input logic rw, input logic mw);
    bus.valid_e    = v;
    bus.ALUResultE = alu;
    bus.WriteDataE = alu ^ 32'hFFFF_0000;
    bus.PCPlus4E   = alu + 32'd4;
    bus.ResultSrcE = alu[1:0];
    bus.modeAddrE  = alu[6:4];
    bus.MemReadE   = alu[3];
    bus.RdE        = rd;
    bus.RegWriteE  = rw;
    bus.MemWriteE  = mw;
  endtask

  int  sent;
  int  cyc;
  bit  acc;

  initial begin
    rst_n       = 1'b0;
    flush_i     = 1'b0;
    bus.ready_m = 1'b0;
    set_e(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("rst_ready_e", 128'(bus.ready_e), 128'(1));
    chk("rst_valid_m", 128'(bus.valid_m), 128'(0));

    // streaming, one per cycle
    bus.ready_m = 1'b1;
    set_e(1'b1, 32'h10, 5'd1, 1'b1, 1'b0); step();
    chk("s_alu_10", 128'(bus.ALUResultM), 128'(32'h10));
    chk("s_v0", 128'(bus.valid_m), 128'(1));
    set_e(1'b1, 32'h20, 5'd2, 1'b1, 1'b0); step();
    chk("s_alu_20", 128'(bus.ALUResultM), 128'(32'h20));
    chk("s_v1", 128'(bus.valid_m), 128'(1));
    set_e(1'b1, 32'h30, 5'd3, 1'b1, 1'b0); step();
    chk("s_alu_30", 128'(bus.ALUResultM), 128'(32'h30));
    chk("s_v2", 128'(bus.valid_m), 128'(1));
    set_e(1'b0, 32'h44, 5'd4, 1'b0, 1'b0); step();
    chk("s_drained", 128'(bus.valid_m), 128'(0));
    chk("s_hold_alu", 128'(bus.ALUResultM), 128'(32'h30));

    // back-pressure
    bus.ready_m = 1'b0;
    set_e(1'b1, 32'hA, 5'd10, 1'b1, 1'b1); step();
    chk("bp_alu_a", 128'(bus.ALUResultM), 128'(32'hA));
    chk("bp_v", 128'(bus.valid_m), 128'(1));
`ifdef EM_SKID_EN
    chk("bp_ready_full", 128'(bus.ready_e), 128'(1));
    set_e(1'b1, 32'hB, 5'd11, 1'b1, 1'b1); step();
    chk("bp_ready_skid", 128'(bus.ready_e), 128'(0));
    chk("bp_alu_a_held", 128'(bus.ALUResultM), 128'(32'hA));
    set_e(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    bus.ready_m = 1'b1; step();
    chk("bp_alu_b", 128'(bus.ALUResultM), 128'(32'hB));
    chk("bp_ready_back", 128'(bus.ready_e), 128'(1));
`else
    chk("bp_ready_comb0", 128'(bus.ready_e), 128'(0));
    set_e(1'b1, 32'hB, 5'd11, 1'b1, 1'b1); step();
    chk("bp_alu_a_held", 128'(bus.ALUResultM), 128'(32'hA));
    bus.ready_m = 1'b1;
    #1 chk("bp_ready_comb1", 128'(bus.ready_e), 128'(1));
    step();
    chk("bp_alu_b", 128'(bus.ALUResultM), 128'(32'hB));
    chk("bp_v_nobubble", 128'(bus.valid_m), 128'(1));
    set_e(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
`endif
    step();
    chk("bp_drained", 128'(bus.valid_m), 128'(0));

    // flush with a simultaneous capture attempt
    bus.ready_m = 1'b0;
    set_e(1'b1, 32'h100, 5'd1, 1'b1, 1'b1); step();
    set_e(1'b1, 32'h200, 5'd2, 1'b1, 1'b1); step();
`ifdef EM_SKID_EN
    chk("fl_in_skid", 128'(bus.ready_e), 128'(0));
`endif
    set_e(1'b1, 32'h700, 5'd7, 1'b1, 1'b1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    set_e(1'b0, 32'h55, 5'd9, 1'b1, 1'b1);
    chk("fl_valid", 128'(bus.valid_m), 128'(0));
    chk("fl_regwr", 128'(bus.RegWriteM), 128'(0));
    chk("fl_memwr", 128'(bus.MemWriteM), 128'(0));

    // bubbles with write enables asserted must stay side-effect free
    bus.ready_m = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bub_regwr", 128'(bus.RegWriteM), 128'(0));
      chk("bub_memwr", 128'(bus.MemWriteM), 128'(0));
    end

    // mixed stream with intermittent back-pressure
    sent = 0;
    cyc  = 0;
    while (sent < 16 && cyc < 200) begin
      bus.ready_m = (cyc % 4 != 3);
      set_e(1'b1, 32'h1000 + 32'(sent) * 32'h11, 5'(sent + 12), sent[0], sent[1]);
      #1 acc = bus.ready_e;
      step();
      if (acc) sent++;
      cyc++;
    end
    chk("stream_sent", 128'(sent), 128'(16));
    set_e(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    bus.ready_m = 1'b1;
    repeat (3) step();
    chk("stream_drained", 128'(bus.valid_m), 128'(0));

    // asynchronous reset with entries held
    bus.ready_m = 1'b0;
    set_e(1'b1, 32'hCAFE, 5'd21, 1'b1, 1'b1); step();
    set_e(1'b1, 32'hBEEF, 5'd22, 1'b1, 1'b1); step();
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 128'(bus.valid_m), 128'(0));
    chk("ar_ctrl", 128'({bus.RegWriteM, bus.MemWriteM, bus.MemReadM}), 128'(0));
    chk("ar_data", 128'({bus.ALUResultM, bus.WriteDataM, bus.PCPlus4M, bus.RdM,
                         bus.ResultSrcM, bus.modeAddrM}), 128'(0));
    set_e(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("ar_rel_ready", 128'(bus.ready_e), 128'(1));
    chk("ar_rel_valid", 128'(bus.valid_m), 128'(0));
    step();

    chk("no_rd7", 128'(seen_rd7), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
